mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port and its MEM-stage data port. It runs a grant/wait-state FSM and drives one global `stall` that freezes the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers until both pending accesses of the current cycle are serviced. It sits between the pipelined datapath (`inst_adr`/`inst`, `data_adr`/`data_out`/`data_in`, `mem_read`/`mem_write`) and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory cycles per access. Legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- if_req  in  1  fetch request; high while the pipeline needs an instruction.
- if_adr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction, registered.
- d_rd  in  1  data load request (EX/MEM mem_read).
- d_wr  in  1  data store request (EX/MEM mem_write).
- d_adr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, registered.
- stall  out  1  pipeline freeze; combinational.
- mem_adr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_rd  out  1  memory read strobe, registered.
- mem_wr  out  1  memory write strobe, registered.
- mem_rdata  in  DATA_W  memory read data; valid in the last cycle of an access.

Behaviour:
- Memory contract:
  - mem_adr, mem_rd/mem_wr and mem_wdata are held stable for exactly MEM_LAT cycles.
  - A write commits at the final edge of the access.
  - mem_rdata is valid during the final cycle and is sampled at its closing edge.
- State: FSM {IDLE, D_ACC, I_ACC}, 4-bit down-counter `cnt`, flags `d_done` and `i_done`.
- stall = ((d_rd|d_wr) & ~d_done) | (if_req & ~i_done).
  - Requestors hold their inputs stable while stall=1.
  - The pipeline advances at every edge where stall=0.
- IDLE with stall=1 (arbitration; data has priority):
  - If data is pending and not done: load the data request into the mem_* regs, cnt=MEM_LAT-1, go to D_ACC.
  - Else, if fetch is pending and not done: load the fetch into the mem_* regs (mem_rd=1), cnt=MEM_LAT-1, go to I_ACC.
- IDLE with stall=0: clear d_done and i_done. No access is started at this edge.
- D_ACC / I_ACC:
  - cnt decrements each edge.
  - At the edge where cnt==0:
    - On a read, capture mem_rdata into d_rdata or if_rdata.
    - Set the matching done flag and drop mem_rd/mem_wr.
  - From D_ACC: if if_req & ~i_done, go directly to I_ACC (mem_rd=1, mem_adr=if_adr, cnt=MEM_LAT-1). Otherwise go to IDLE.
  - From I_ACC: go to IDLE.
- Timing:
  - Fetch-only cycle: stall high for MEM_LAT+1 cycles, then low for 1 cycle (period MEM_LAT+2).
  - Data+fetch cycle: period 2*MEM_LAT+2.
  - No requests: stall=0, no memory activity.
- d_rd & d_wr together is illegal. Treat it as a store and flag it with a simulation assertion.
- A store never modifies d_rdata. if_rdata and d_rdata hold their last captured value until overwritten.
- Reset (asynchronous, at any time, including mid-access):
  - State IDLE, cnt=0, done flags 0.
  - mem_rd=0, mem_wr=0, mem_adr=0, mem_wdata=0, if_rdata=0, d_rdata=0.
  - An in-flight write is aborted: mem_wr drops immediately.
  - stall follows its equation with the done flags at 0.
- The arbiter does not handle flush. A flushed fetch still completes; the datapath discards it.

Decomposition:
- Shared package `arb_pkg`:
  - State encoding localparams: IDLE=2'd0, D_ACC=2'd1, I_ACC=2'd2.
  - Default MEM_LAT.
  - Counter width constant (4).
- One sub-module: `wait_counter` (loadable 4-bit down-counter with `load`, `val`, `zero` outputs, async active-low clear).

Test Plan:
- Reset mid-store: assert rst=0 during D_ACC with mem_wr=1 -> mem_wr=0, mem_rd=0, mem_adr=0 in the same cycle; if_rdata=d_rdata=0; on release, FSM restarts from IDLE.
- Fetch only, MEM_LAT=2: if_req=1, if_adr=0x40, memory returns 0x8C080004 -> cycle0 stall=1 (IDLE); cycles1-2 mem_rd=1, mem_adr=0x40; cycle3 if_rdata=0x8C080004, stall=0.
- Load+fetch, MEM_LAT=2: d_rd adr 0x100 (mem 0xDEADBEEF), if_adr 0x44 -> cycles1-2 mem_adr=0x100; cycles3-4 mem_adr=0x44; cycle5 stall=0, d_rdata=0xDEADBEEF.
- Store+fetch: d_wr adr 0x200, d_wdata 0x12345678 -> mem_wr=1 exactly 2 cycles with those values, mem_rd=0 in those cycles, then the fetch; d_rdata unchanged.
- No requests: if_req=0, d_rd=d_wr=0 -> stall=0, mem_rd=mem_wr=0 for 10 cycles.
- MEM_LAT=1, continuous fetch 0x0,0x4,0x8 -> if_rdata updates every 3 cycles; stall pattern 1,1,0 repeating.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding,
// wait-counter width and the default memory latency.
package arb_pkg;

  localparam int CNT_W       = 4;
  localparam int DEF_MEM_LAT = 2;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] D_ACC_ENC = 2'd1;
  localparam logic [1:0] I_ACC_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    D_ACC = D_ACC_ENC,
    I_ACC = I_ACC_ENC
  } state_e;

  // Counter preload so the access spans exactly lat cycles (last cycle at cnt==0).
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter, plus FSM debug taps.
// Handshake: a requestor raises if_req / d_rd / d_wr and holds address and
// data stable while stall=1; the request is serviced at the edge where stall=0.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_adr;
  logic [DATA_W-1:0] if_rdata;
  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_adr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              stall;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbg_state;
  logic [3:0]        dbg_cnt;

  modport slave (
    input  if_req, if_adr, d_rd, d_wr, d_adr, d_wdata, mem_rdata,
    output if_rdata, d_rdata, stall, mem_adr, mem_wdata, mem_rd, mem_wr,
           dbg_state, dbg_cnt
  );

  modport master (
    output if_req, if_adr, d_rd, d_wr, d_adr, d_wdata, mem_rdata,
    input  if_rdata, d_rdata, stall, mem_adr, mem_wdata, mem_rd, mem_wr,
           dbg_state, dbg_cnt
  );
endinterface

// File: rtl/wait_counter.sv
// Loadable down-counter timing one memory access; saturates at zero.
module wait_counter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign val  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Time-shares one fixed-latency memory between instruction fetch and the
// MEM-stage data port; data wins arbitration and the pipeline stalls until both are done.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

  state_e            state_q, state_d;
  logic              d_done_q, d_done_d;
  logic              i_done_q, i_done_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             d_pend, i_pend, stall;

  wait_counter u_wait_counter (
    .clk      (clk),
    .rst_n    (rst),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .en       (cnt_en),
    .val      (cnt_val),
    .zero     (cnt_zero)
  );

  assign d_pend = (bus.d_rd | bus.d_wr) & ~d_done_q;
  assign i_pend = bus.if_req & ~i_done_q;
  assign stall  = d_pend | i_pend;

  always_comb begin
    state_d     = state_q;
    d_done_d    = d_done_q;
    i_done_d    = i_done_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_pend) begin
          // Simultaneous d_rd and d_wr is treated as a store.
          mem_adr_d   = bus.d_adr;
          mem_wdata_d = bus.d_wdata;
          mem_wr_d    = bus.d_wr;
          mem_rd_d    = ~bus.d_wr;
          cnt_load    = 1'b1;
          state_d     = D_ACC;
        end else if (i_pend) begin
          mem_adr_d = bus.if_adr;
          mem_rd_d  = 1'b1;
          mem_wr_d  = 1'b0;
          cnt_load  = 1'b1;
          state_d   = I_ACC;
        end else begin
          // Pipeline advances at this edge; arm both ports for the next cycle.
          d_done_d = 1'b0;
          i_done_d = 1'b0;
        end
      end
      D_ACC: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          if (mem_rd_q) d_rdata_d = bus.mem_rdata;
          d_done_d = 1'b1;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          state_d  = IDLE;
          if (i_pend) begin
            mem_adr_d = bus.if_adr;
            mem_rd_d  = 1'b1;
            cnt_load  = 1'b1;
            state_d   = I_ACC;
          end
        end
      end
      I_ACC: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          if_rdata_d = bus.mem_rdata;
          i_done_d   = 1'b1;
          mem_rd_d   = 1'b0;
          mem_wr_d   = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      d_done_q    <= d_done_d;
      i_done_q    <= i_done_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_cnt   = cnt_val;

  illegal_rd_wr: assert property (@(posedge clk) disable iff (!rst) !(bus.d_rd && bus.d_wr));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of the memory port arbiter at MEM_LAT=2
// and MEM_LAT=1 against a bench-owned memory model and reference copy.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut0 (
    .clk (clk), .rst (rst), .bus (b0.slave)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );

  // memory model: combinational read, commit on edges with mem_wr
  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];
  logic        pl_en;
  logic [7:0]  pl_adr;
  logic [31:0] pl_dat;

  always_ff @(posedge clk) begin
    if (pl_en)          mem_arr[pl_adr]          <= pl_dat;
    else if (b0.mem_wr) mem_arr[b0.mem_adr[9:2]] <= b0.mem_wdata;
  end
  assign b0.mem_rdata = mem_arr[b0.mem_adr[9:2]];
  assign b1.mem_rdata = mem_arr[b1.mem_adr[9:2]];

  // scoreboard
  logic [31:0] iexp_q [$];
  logic [31:0] dexp_q [$];
  logic [31:0] iexp1_q [$];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_if, last_dr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] w, input logic [31:0] d);
    pl_en = 1'b1; pl_adr = w; pl_dat = d;
    ref_mem[w] = d;
    step();
    pl_en = 1'b0;
  endtask

  // Waits for stall to drop on b0 and checks how many cycles it took.
  task automatic wait_release(input string tag, input int exp_cycles);
    int n = 0;
    while (b0.stall !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    if (b0.stall !== 1'b0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_timeout observed=stall_high expected=release", tag);
    end else begin
      chk({tag, "_lat"}, 32'(n), 32'(exp_cycles));
    end
  endtask

  task automatic idle_inputs();
    b0.if_req = 1'b0; b0.if_adr = '0; b0.d_rd = 1'b0; b0.d_wr = 1'b0;
    b0.d_adr = '0; b0.d_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    pl_en = 1'b0; pl_adr = '0; pl_dat = '0;
    idle_inputs();
    b1.if_req = 1'b0; b1.if_adr = '0; b1.d_rd = 1'b0; b1.d_wr = 1'b0;
    b1.d_adr = '0; b1.d_wdata = '0;
    #2;

    // reset state
    chk("rst_stall",    32'(b0.stall), 0);
    chk("rst_mem_rd",   32'(b0.mem_rd), 0);
    chk("rst_mem_wr",   32'(b0.mem_wr), 0);
    chk("rst_mem_adr",  b0.mem_adr, 0);
    chk("rst_if_rdata", b0.if_rdata, 0);
    chk("rst_d_rdata",  b0.d_rdata, 0);
    chk("rst_state",    32'(b0.dbg_state), 32'(IDLE_ENC));

    // preload memory under reset
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    preload(8'h10, 32'h8C080004);
    preload(8'h11, 32'h2108000C);
    preload(8'h12, 32'hAC0A0008);
    preload(8'h40, 32'hDEADBEEF);
    preload(8'h00, 32'h11111111);
    preload(8'h01, 32'h22222222);
    preload(8'h02, 32'h33333333);
    @(negedge clk);
    rst = 1'b1;
    step();

    // no requests
    for (int i = 0; i < 10; i++) begin
      chk("idle_stall",  32'(b0.stall), 0);
      chk("idle_mem_rd", 32'(b0.mem_rd), 0);
      chk("idle_mem_wr", 32'(b0.mem_wr), 0);
      step();
    end

    // fetch only
    b0.if_req = 1'b1; b0.if_adr = 32'h40;
    iexp_q.push_back(32'h8C080004);
    #1;
    chk("f_c0_stall", 32'(b0.stall), 1);
    chk("f_c0_state", 32'(b0.dbg_state), 32'(IDLE_ENC));
    for (int c = 1; c <= 2; c++) begin
      step();
      chk("f_mem_rd",  32'(b0.mem_rd), 1);
      chk("f_mem_adr", b0.mem_adr, 32'h40);
      chk("f_stall",   32'(b0.stall), 1);
    end
    step();
    chk("f_c3_stall", 32'(b0.stall), 0);
    chk("f_if_rdata", b0.if_rdata, iexp_q.pop_front());
    step();
    idle_inputs();

    // load + fetch
    b0.d_rd = 1'b1; b0.d_adr = 32'h100; b0.if_req = 1'b1; b0.if_adr = 32'h44;
    dexp_q.push_back(32'hDEADBEEF);
    iexp_q.push_back(32'h2108000C);
    #1;
    chk("lf_c0_stall", 32'(b0.stall), 1);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("lf_mem_adr", b0.mem_adr, (c <= 2) ? 32'h100 : 32'h44);
      chk("lf_mem_rd",  32'(b0.mem_rd), 1);
      chk("lf_stall",   32'(b0.stall), 1);
    end
    step();
    chk("lf_c5_stall", 32'(b0.stall), 0);
    chk("lf_d_rdata",  b0.d_rdata, dexp_q.pop_front());
    chk("lf_if_rdata", b0.if_rdata, iexp_q.pop_front());
    step();
    idle_inputs();

    // store + fetch
    b0.d_wr = 1'b1; b0.d_adr = 32'h200; b0.d_wdata = 32'h12345678;
    b0.if_req = 1'b1; b0.if_adr = 32'h48;
    ref_mem[8'h80] = 32'h12345678;
    iexp_q.push_back(32'hAC0A0008);
    dexp_q.push_back(32'hDEADBEEF);
    #1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c <= 2) begin
        chk("sf_mem_wr",    32'(b0.mem_wr), 1);
        chk("sf_mem_rd",    32'(b0.mem_rd), 0);
        chk("sf_mem_adr",   b0.mem_adr, 32'h200);
        chk("sf_mem_wdata", b0.mem_wdata, 32'h12345678);
      end else begin
        chk("sf_f_mem_wr",  32'(b0.mem_wr), 0);
        chk("sf_f_mem_rd",  32'(b0.mem_rd), 1);
        chk("sf_f_mem_adr", b0.mem_adr, 32'h48);
      end
    end
    step();
    chk("sf_c5_stall", 32'(b0.stall), 0);
    chk("sf_if_rdata", b0.if_rdata, iexp_q.pop_front());
    chk("sf_d_rdata",  b0.d_rdata, dexp_q.pop_front());
    chk("sf_commit",   mem_arr[8'h80], ref_mem[8'h80]);
    step();
    idle_inputs();
    last_if = 32'hAC0A0008;
    last_dr = 32'hDEADBEEF;

    // randomized mixes
    for (int t = 0; t < 12; t++) begin
      int kind;
      logic [7:0] fw, dw;
      logic [31:0] wd;
      kind = $urandom_range(0, 3);
      fw = 8'($urandom_range(0, 127));
      dw = 8'($urandom_range(128, 255));
      wd = $urandom;
      idle_inputs();
      if (kind != 3) begin
        b0.if_req = 1'b1; b0.if_adr = {22'd0, fw, 2'b00};
        last_if = ref_mem[fw];
      end
      if (kind == 1 || kind == 3) begin
        b0.d_rd = 1'b1; b0.d_adr = {22'd0, dw, 2'b00};
        last_dr = ref_mem[dw];
      end
      if (kind == 2) begin
        b0.d_wr = 1'b1; b0.d_adr = {22'd0, dw, 2'b00}; b0.d_wdata = wd;
        ref_mem[dw] = wd;
      end
      iexp_q.push_back(last_if);
      dexp_q.push_back(last_dr);
      #1;
      wait_release("rnd", (kind == 1 || kind == 2) ? 5 : 3);
      chk("rnd_if_rdata", b0.if_rdata, iexp_q.pop_front());
      chk("rnd_d_rdata",  b0.d_rdata, dexp_q.pop_front());
      if (kind == 2) chk("rnd_commit", mem_arr[dw], ref_mem[dw]);
      step();
    end
    idle_inputs();
    step();

    // reset in the middle of a store
    b0.d_wr = 1'b1; b0.d_adr = 32'h300; b0.d_wdata = 32'hCAFEF00D;
    step();
    chk("rs_mem_wr_pre", 32'(b0.mem_wr), 1);
    chk("rs_state_pre",  32'(b0.dbg_state), 32'(D_ACC_ENC));
    #2 rst = 1'b0;
    #1;
    chk("rs_mem_wr",   32'(b0.mem_wr), 0);
    chk("rs_mem_rd",   32'(b0.mem_rd), 0);
    chk("rs_mem_adr",  b0.mem_adr, 0);
    chk("rs_if_rdata", b0.if_rdata, 0);
    chk("rs_d_rdata",  b0.d_rdata, 0);
    chk("rs_state",    32'(b0.dbg_state), 32'(IDLE_ENC));
    chk("rs_stall",    32'(b0.stall), 1);
    idle_inputs();
    #1;
    chk("rs_stall_idle", 32'(b0.stall), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rs_post_state", 32'(b0.dbg_state), 32'(IDLE_ENC));
    chk("rs_no_commit",  mem_arr[8'hC0], ref_mem[8'hC0]);
    b0.if_req = 1'b1; b0.if_adr = 32'h40;
    iexp_q.push_back(32'h8C080004);
    #1;
    wait_release("rs_restart", 3);
    chk("rs_restart_if", b0.if_rdata, iexp_q.pop_front());
    step();
    idle_inputs();

    // MEM_LAT=1 continuous fetch
    for (int k = 0; k < 3; k++) begin
      b1.if_req = 1'b1; b1.if_adr = 32'(k * 4);
      iexp1_q.push_back(ref_mem[k]);
      #1;
      chk("l1_c0_stall", 32'(b1.stall), 1);
      step();
      chk("l1_c1_stall",   32'(b1.stall), 1);
      chk("l1_c1_mem_rd",  32'(b1.mem_rd), 1);
      chk("l1_c1_mem_adr", b1.mem_adr, 32'(k * 4));
      step();
      chk("l1_c2_stall",    32'(b1.stall), 0);
      chk("l1_c2_if_rdata", b1.if_rdata, iexp1_q.pop_front());
      step();
    end
    b1.if_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
